reg_file_controller: RTL and testbench
======================================

# reg_file_controller

Command sequencer that owns the single port of the register file and drives it on behalf of an upstream master. It accepts READ / WRITE / MOVE / ADD commands over a valid/ready handshake. It converts each command into the correct sequence of load, select and data cycles, including the one-cycle registered read latency of the register file, and returns a result over a valid/ready response channel. It sits between the core's control logic and the register file and is the only block allowed to drive the register file port.

## Interface
- SELECT_WIDTH, 4, width of register select / address fields
- REG_WIDTH, 8, width of one register
- NUM_REGS, 4, writable addresses are 0..NUM_REGS-1; all other addresses are read-only

- i_clk  in  1  clock, rising edge
- i_rstN  in  1  reset, asynchronous, active-low
- i_cmdValid  in  1  command valid
- o_cmdReady  out  1  command ready
- i_cmdOp  in  2  00 READ, 01 WRITE, 10 MOVE, 11 ADD
- i_cmdDst  in  SELECT_WIDTH  destination address (WRITE/MOVE/ADD)
- i_cmdSrc  in  SELECT_WIDTH  source address (READ/MOVE)
- i_cmdData  in  REG_WIDTH  write data (WRITE) / addend (ADD)
- o_rspValid  out  1  response valid
- i_rspReady  in  1  response ready
- o_rspData  out  REG_WIDTH  result value
- o_rspErr  out  1  command rejected
- o_ldSig  out  1  register file load signal
- o_regSel  out  SELECT_WIDTH  register file select
- o_regData  out  REG_WIDTH  register file data in
- i_regData  in  REG_WIDTH  register file data out, registered and valid one edge after a non-load cycle

## Operation
- States: IDLE, RD, CAP, WR, RSP. All outputs are registered.
- IDLE: o_cmdReady=1, o_ldSig=0. Acceptance occurs when i_cmdValid && o_cmdReady at an edge. All command fields are latched only at acceptance.
- Destination check at acceptance: for WRITE/MOVE/ADD with i_cmdDst >= NUM_REGS, go to RSP with o_rspErr=1, o_rspData=0. No register file cycle is issued. READ is never rejected.
- READ: IDLE→RD (o_regSel=src, o_ldSig=0)→CAP (i_regData captured at the CAP edge)→RSP, o_rspData=captured value.
- WRITE: IDLE→WR (o_ldSig=1, o_regSel=dst, o_regData=data)→RSP, o_rspData=data.
- MOVE: RD/CAP on src, then WR dst with the captured value. o_rspData=moved value.
- ADD: RD/CAP on dst, then WR dst with (captured + cmdData) mod 2^REG_WIDTH. Carry is discarded. o_rspData=sum.
- Read-only addresses return the register file's own values: 8→0x00, 9→0x01, 10→0xFF, others→0x00.
- o_ldSig is high for exactly one cycle per write and only in WR. When leaving WR, o_ldSig returns to 0; o_regSel holds its value.
- RSP: o_rspValid=1. o_rspData/o_rspErr are stable until i_rspReady. On handshake, go to IDLE.

## Timing
- Reset (asynchronous, immediate): state IDLE, o_cmdReady=0, o_rspValid=0, o_rspData=0, o_rspErr=0, o_ldSig=0, o_regSel=0, o_regData=0. o_cmdReady rises on the first edge after reset deassertion.
- Latency from acceptance edge to o_rspValid high:
  - WRITE: 2 edges.
  - READ: 3 edges.
  - MOVE/ADD: 4 edges.
  - Rejected command: 1 edge.
- Response handshake at an edge: o_rspValid falls and o_cmdReady rises on that same edge. There is no acceptance in the handshake cycle, so back-to-back commands have a minimum spacing of latency+1 cycles.
- o_cmdReady=0 in every state except IDLE. A command presented while busy is not accepted and must be held by the master.
- Reset mid-operation aborts the command and drops o_ldSig immediately. No response is produced. Register file contents are not touched by this block's reset; a write is either fully issued at an edge or not at all.
- Back-to-back RD after WR is safe: the register file write completes at the WR edge, so a following RD sees the new value.

## Test plan
- Reset with outputs forced: all outputs 0 during reset; o_cmdReady=1 one edge after release; no o_ldSig pulse.
- WRITE dst=2 data=0x5A -> one cycle of o_ldSig=1, o_regSel=2, o_regData=0x5A; response 0x5A/err 0 two edges after acceptance. Then READ src=2 -> 0x5A three edges after acceptance.
- READ src=8, 9, 10, 4 -> responses 0x00, 0x01, 0xFF, 0x00 respectively; o_ldSig stays 0.
- WRITE dst=1 data=0xF0, then ADD dst=1 data=0x20 -> response 0x10 (wrap). A subsequent READ src=1 returns 0x10.
- MOVE src=10 dst=3 -> reg3=0xFF, response 0xFF four edges after acceptance. WRITE dst=9 data=0x33 -> err=1, data 0x00, no o_ldSig pulse.
- Backpressure and reset:
  - Hold i_rspReady=0 for 5 cycles -> o_rspValid, o_rspData and o_rspErr held stable, o_cmdReady=0.
  - Assert i_rstN=0 while in WR of a MOVE -> o_ldSig=0 immediately, no response, o_cmdReady=1 one edge after release.

Source files
------------

// File: rtl/reg_file_controller.sv
// reg_file_controller
//   Sequences READ / WRITE / MOVE / ADD commands onto the single port of a
//   register file whose read data is registered (valid one edge after a
//   non-load cycle). It is the only driver of that port.
//
// Ports
//   i_clk, i_rstN                : clock (rising edge), async active-low reset
//   i_cmdValid / o_cmdReady      : command handshake
//   i_cmdOp                      : 00 READ, 01 WRITE, 10 MOVE, 11 ADD
//   i_cmdDst / i_cmdSrc          : destination / source register address
//   i_cmdData                    : write data (WRITE) or addend (ADD)
//   o_rspValid / i_rspReady      : response handshake
//   o_rspData / o_rspErr         : result value / rejected-command flag
//   o_ldSig, o_regSel, o_regData : register file load, select, data in
//   i_regData                    : register file data out
module reg_file_controller #(
    parameter int SELECT_WIDTH = 4,
    parameter int REG_WIDTH    = 8,
    parameter int NUM_REGS     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rstN,
    input  logic                    i_cmdValid,
    output logic                    o_cmdReady,
    input  logic [1:0]              i_cmdOp,
    input  logic [SELECT_WIDTH-1:0] i_cmdDst,
    input  logic [SELECT_WIDTH-1:0] i_cmdSrc,
    input  logic [REG_WIDTH-1:0]    i_cmdData,
    output logic                    o_rspValid,
    input  logic                    i_rspReady,
    output logic [REG_WIDTH-1:0]    o_rspData,
    output logic                    o_rspErr,
    output logic                    o_ldSig,
    output logic [SELECT_WIDTH-1:0] o_regSel,
    output logic [REG_WIDTH-1:0]    o_regData,
    input  logic [REG_WIDTH-1:0]    i_regData
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RSP
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [SELECT_WIDTH-1:0] dst_q, dst_d;
    logic [REG_WIDTH-1:0]    data_q, data_d;

    logic                    cmdReady_q, cmdReady_d;
    logic                    rspValid_q, rspValid_d;
    logic [REG_WIDTH-1:0]    rspData_q, rspData_d;
    logic                    rspErr_q, rspErr_d;
    logic                    ldSig_q, ldSig_d;
    logic [SELECT_WIDTH-1:0] regSel_q, regSel_d;
    logic [REG_WIDTH-1:0]    regData_q, regData_d;

    logic [31:0]             dstExt;
    logic                    dstInvalid;

    assign dstExt     = 32'(i_cmdDst);
    assign dstInvalid = (dstExt >= 32'(NUM_REGS));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dst_d      = dst_q;
        data_d     = data_q;
        cmdReady_d = cmdReady_q;
        rspValid_d = rspValid_q;
        rspData_d  = rspData_q;
        rspErr_d   = rspErr_q;
        ldSig_d    = 1'b0;
        regSel_d   = regSel_q;
        regData_d  = regData_q;

        unique case (state_q)
            S_IDLE: begin
                cmdReady_d = 1'b1;
                // cmdReady_q gates acceptance so the first edge after reset
                // only raises ready.
                if (i_cmdValid && cmdReady_q) begin
                    cmdReady_d = 1'b0;
                    op_d       = i_cmdOp;
                    dst_d      = i_cmdDst;
                    data_d     = i_cmdData;
                    if (i_cmdOp != OP_READ && dstInvalid) begin
                        state_d    = S_RSP;
                        rspValid_d = 1'b1;
                        rspErr_d   = 1'b1;
                        rspData_d  = '0;
                    end else if (i_cmdOp == OP_WRITE) begin
                        state_d   = S_WR;
                        ldSig_d   = 1'b1;
                        regSel_d  = i_cmdDst;
                        regData_d = i_cmdData;
                    end else begin
                        // ADD reads its own destination; READ/MOVE read src.
                        state_d  = S_RD;
                        regSel_d = (i_cmdOp == OP_READ || i_cmdOp == OP_MOVE) ?
                                   i_cmdSrc : i_cmdDst;
                    end
                end
            end
            S_RD: begin
                // Register file samples the select on this edge.
                state_d = S_CAP;
            end
            S_CAP: begin
                if (op_q == OP_READ) begin
                    state_d    = S_RSP;
                    rspValid_d = 1'b1;
                    rspData_d  = i_regData;
                    rspErr_d   = 1'b0;
                end else begin
                    state_d   = S_WR;
                    ldSig_d   = 1'b1;
                    regSel_d  = dst_q;
                    // MOVE copies; ADD wraps modulo 2^REG_WIDTH.
                    regData_d = (op_q == OP_MOVE) ? i_regData : i_regData + data_q;
                end
            end
            S_WR: begin
                // The value just written is the response for every write op.
                state_d    = S_RSP;
                rspValid_d = 1'b1;
                rspData_d  = regData_q;
                rspErr_d   = 1'b0;
            end
            S_RSP: begin
                if (i_rspReady) begin
                    state_d    = S_IDLE;
                    rspValid_d = 1'b0;
                    cmdReady_d = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                cmdReady_d = 1'b0;
                rspValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            cmdReady_q <= 1'b0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspErr_q   <= 1'b0;
            ldSig_q    <= 1'b0;
            regSel_q   <= '0;
            regData_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dst_q      <= dst_d;
            data_q     <= data_d;
            cmdReady_q <= cmdReady_d;
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
            rspErr_q   <= rspErr_d;
            ldSig_q    <= ldSig_d;
            regSel_q   <= regSel_d;
            regData_q  <= regData_d;
        end
    end

    assign o_cmdReady = cmdReady_q;
    assign o_rspValid = rspValid_q;
    assign o_rspData  = rspData_q;
    assign o_rspErr   = rspErr_q;
    assign o_ldSig    = ldSig_q;
    assign o_regSel   = regSel_q;
    assign o_regData  = regData_q;

endmodule

// File: tb/tb_reg_file_controller.sv
module tb_reg_file_controller;

    logic       clk = 1'b0;
    logic       rstN;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;
    logic [3:0] cmdDst, cmdSrc;
    logic [7:0] cmdData;
    logic       rspValid, rspReady;
    logic [7:0] rspData;
    logic       rspErr;
    logic       ldSig;
    logic [3:0] regSel;
    logic [7:0] regDataOut, regDataIn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_controller #(.SELECT_WIDTH(4), .REG_WIDTH(8), .NUM_REGS(4)) dut (
        .i_clk(clk), .i_rstN(rstN),
        .i_cmdValid(cmdValid), .o_cmdReady(cmdReady),
        .i_cmdOp(cmdOp), .i_cmdDst(cmdDst), .i_cmdSrc(cmdSrc), .i_cmdData(cmdData),
        .o_rspValid(rspValid), .i_rspReady(rspReady),
        .o_rspData(rspData), .o_rspErr(rspErr),
        .o_ldSig(ldSig), .o_regSel(regSel), .o_regData(regDataOut),
        .i_regData(regDataIn)
    );

    // Register file environment: registered read, write on load.
    logic [7:0] rf [0:3];
    logic [7:0] rfRd;
    assign regDataIn = rfRd;

    function automatic logic [7:0] rfValue(input logic [3:0] a);
        if (a < 4)       return rf[a[1:0]];
        else if (a == 9) return 8'h01;
        else if (a == 10) return 8'hFF;
        else             return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (ldSig) begin
            if (regSel < 4) rf[regSel[1:0]] <= regDataOut;
        end else begin
            rfRd <= rfValue(regSel);
        end
    end

    // Behavioural reference: architectural register contents.
    logic [7:0] refRegs [0:3];

    function automatic logic [7:0] refRead(input logic [3:0] a);
        if (a < 4)        return refRegs[a[1:0]];
        else if (a == 9)  return 8'h01;
        else if (a == 10) return 8'hFF;
        else              return 8'h00;
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] dst,
                          input logic [3:0] src, input logic [7:0] data,
                          input int hold);
        logic [7:0] expVal;
        logic       expErr, expWr;
        int         expLat, edges, ldCnt, w;
        logic [3:0] ldSel;
        logic [7:0] ldDat;
        logic       busyReady;
        expErr = 1'b0; expWr = 1'b0; expVal = 8'h00; expLat = 0;
        ldSel = 4'h0; ldDat = 8'h00;
        if (op != 2'b00 && dst >= 4) begin
            expErr = 1'b1; expLat = 1;
        end else begin
            case (op)
                2'b00: begin expVal = refRead(src); expLat = 3; end
                2'b01: begin expVal = data; expWr = 1'b1; expLat = 2; end
                2'b10: begin expVal = refRead(src); expWr = 1'b1; expLat = 4; end
                default: begin expVal = refRegs[dst[1:0]] + data; expWr = 1'b1; expLat = 4; end
            endcase
        end

        @(negedge clk);
        w = 0;
        while (!cmdReady && w < 20) begin @(negedge clk); w++; end
        checks++;
        if (cmdReady !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_timeout: got %b expected 1", cmdReady);
            return;
        end
        cmdValid = 1'b1; cmdOp = op; cmdDst = dst; cmdSrc = src; cmdData = data;
        @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b0;
        edges = 1; ldCnt = 0; busyReady = 1'b0;
        while (edges < 10) begin
            if (ldSig) begin ldCnt++; ldSel = regSel; ldDat = regDataOut; end
            if (rspValid) break;
            if (cmdReady) busyReady = 1'b1;
            @(posedge clk); @(negedge clk);
            edges++;
        end
        checks++;
        if (rspValid !== 1'b1) begin
            errors++; $display("FAIL rsp_timeout op=%0d: got valid %b expected 1", op, rspValid);
        end
        checks++;
        if (edges != expLat) begin
            errors++; $display("FAIL latency op=%0d: got %0d expected %0d", op, edges, expLat);
        end
        checks++;
        if (rspData !== expVal) begin
            errors++; $display("FAIL rsp_data op=%0d dst=%0d src=%0d: got %h expected %h", op, dst, src, rspData, expVal);
        end
        checks++;
        if (rspErr !== expErr) begin
            errors++; $display("FAIL rsp_err op=%0d dst=%0d: got %b expected %b", op, dst, rspErr, expErr);
        end
        checks++;
        if (ldCnt != (expWr ? 1 : 0)) begin
            errors++; $display("FAIL ld_pulses op=%0d: got %0d expected %0d", op, ldCnt, expWr ? 1 : 0);
        end
        if (expWr) begin
            checks++;
            if (ldSel !== dst || ldDat !== expVal) begin
                errors++; $display("FAIL write_port op=%0d: got sel %0d data %h expected sel %0d data %h", op, ldSel, ldDat, dst, expVal);
            end
        end
        checks++;
        if (busyReady !== 1'b0) begin
            errors++; $display("FAIL ready_while_busy op=%0d: got 1 expected 0", op);
        end

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (rspValid !== 1'b1 || rspData !== expVal || rspErr !== expErr || cmdReady !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got v%b d%h e%b r%b expected v1 d%h e%b r0",
                         i, rspValid, rspData, rspErr, cmdReady, expVal, expErr);
            end
        end

        rspReady = 1'b1;
        @(posedge clk); @(negedge clk);
        rspReady = 1'b0;
        checks++;
        if (rspValid !== 1'b0 || cmdReady !== 1'b1) begin
            errors++; $display("FAIL handshake: got valid %b ready %b expected valid 0 ready 1", rspValid, cmdReady);
        end
        if (expWr) refRegs[dst[1:0]] = expVal;
    endtask

    task automatic test_reset;
        rstN = 1'b0; cmdValid = 1'b1; rspReady = 1'b1;
        cmdOp = 2'b01; cmdDst = 4'd1; cmdSrc = 4'd0; cmdData = 8'hAA;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({cmdReady, rspValid, rspData, rspErr, ldSig, regSel, regDataOut} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy%b v%b d%h e%b ld%b sel%h wd%h expected all 0",
                     cmdReady, rspValid, rspData, rspErr, ldSig, regSel, regDataOut);
        end
        rstN = 1'b1; cmdValid = 1'b0; rspReady = 1'b0;
        #1;
        checks++;
        if (cmdReady !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge: got %b expected 0", cmdReady);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (cmdReady !== 1'b1 || ldSig !== 1'b0 || rspValid !== 1'b0) begin
            errors++; $display("FAIL ready_after_release: got rdy %b ld %b v %b expected 1 0 0", cmdReady, ldSig, rspValid);
        end
    endtask

    task automatic test_write_read;
        do_cmd(2'b01, 4'd2, 4'd0, 8'h5A, 0);
        do_cmd(2'b00, 4'd0, 4'd2, 8'h00, 0);
    endtask

    task automatic test_readonly;
        do_cmd(2'b00, 4'd0, 4'd8, 8'h00, 0);
        do_cmd(2'b00, 4'd0, 4'd9, 8'h00, 0);
        do_cmd(2'b00, 4'd0, 4'd10, 8'h00, 0);
        do_cmd(2'b00, 4'd0, 4'd4, 8'h00, 0);
    endtask

    task automatic test_add_wrap;
        do_cmd(2'b01, 4'd1, 4'd0, 8'hF0, 0);
        do_cmd(2'b11, 4'd1, 4'd0, 8'h20, 0);
        do_cmd(2'b00, 4'd0, 4'd1, 8'h00, 0);
    endtask

    task automatic test_move_reject;
        do_cmd(2'b10, 4'd3, 4'd10, 8'h00, 0);
        do_cmd(2'b01, 4'd9, 4'd0, 8'h33, 0);
        do_cmd(2'b00, 4'd0, 4'd3, 8'h00, 0);
    endtask

    task automatic test_backpressure;
        do_cmd(2'b00, 4'd0, 4'd3, 8'h00, 5);
        do_cmd(2'b11, 4'd12, 4'd0, 8'h01, 5);
    endtask

    task automatic test_reset_mid;
        do_cmd(2'b01, 4'd0, 4'd0, 8'h77, 0);
        @(negedge clk);
        cmdValid = 1'b1; cmdOp = 2'b10; cmdDst = 4'd0; cmdSrc = 4'd9; cmdData = 8'h00;
        @(posedge clk); @(negedge clk);
        cmdValid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++;
        if (ldSig !== 1'b1) begin
            errors++; $display("FAIL move_in_wr: got ld %b expected 1", ldSig);
        end
        rstN = 1'b0;
        #1;
        checks++;
        if (ldSig !== 1'b0 || rspValid !== 1'b0 || cmdReady !== 1'b0) begin
            errors++; $display("FAIL async_reset: got ld %b v %b rdy %b expected 0 0 0", ldSig, rspValid, cmdReady);
        end
        @(posedge clk); @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (cmdReady !== 1'b1 || rspValid !== 1'b0) begin
            errors++; $display("FAIL after_abort: got rdy %b v %b expected 1 0", cmdReady, rspValid);
        end
        do_cmd(2'b00, 4'd0, 4'd0, 8'h00, 0);
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [3:0] dst, src;
        logic [7:0] data;
        for (int n = 0; n < 40; n++) begin
            op   = 2'($urandom_range(0, 3));
            dst  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            src  = 4'($urandom_range(0, 15));
            data = 8'($urandom);
            do_cmd(op, dst, src, data, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin rf[i] = 8'h00; refRegs[i] = 8'h00; end
        rfRd = 8'h00;
        test_reset();
        test_write_read();
        test_readonly();
        test_add_wrap();
        test_move_reject();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
